board_loader: RTL and testbench

BOARD_LOADER -- requirements
Module: board_loader

---
 rtl/sudoku_pkg.sv | 18 +
 rtl/board_loader_if.sv | 31 +++
 rtl/board_loader.sv | 158 +++++++++++++++
 tb/tb_board_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared widths, limits and the loader state encoding for the sudoku board path.
package sudoku_pkg;
   localparam int NUM_CELLS  = 81;
   localparam int CELL_IDX_W = 7;
   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGIT  = 9;
   localparam int SUM_W      = 10;

   localparam logic [CELL_IDX_W-1:0] CHECKSUM_ERR_CELL = 7'h7F;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      VERIFY,
      DONE,
      ERROR
   } loader_state_t;
endpackage

// File: rtl/board_loader_if.sv
// Digit stream, board-memory bus and status signals of the board loader.
// slave is the loader's view; master is the view of the parent/driver.
interface board_loader_if;
   import sudoku_pkg::*;

   logic                  start;
   logic                  in_valid;
   logic [DIGIT_W-1:0]    in_digit;
   logic                  in_ready;
   logic                  mem_write_en;
   logic                  mem_read_en;
   logic [CELL_IDX_W-1:0] mem_cell_index;
   logic [DIGIT_W-1:0]    mem_data_in;
   logic [DIGIT_W-1:0]    mem_data_out;
   logic                  busy;
   logic                  load_done;
   logic                  load_error;
   logic [CELL_IDX_W-1:0] err_cell;

   modport slave (
      input  start, in_valid, in_digit, mem_data_out,
      output in_ready, mem_write_en, mem_read_en, mem_cell_index, mem_data_in,
             busy, load_done, load_error, err_cell
   );

   modport master (
      output start, in_valid, in_digit, mem_data_out,
      input  in_ready, mem_write_en, mem_read_en, mem_cell_index, mem_data_in,
             busy, load_done, load_error, err_cell
   );
endinterface

// File: rtl/board_loader.sv
// Streams puzzle digits into the external board memory, rejecting illegal digits.
// Define LOADER_READBACK_EN to add a read-back checksum pass (VERIFY) after loading.
module board_loader #(
   parameter int NUM_CELLS = sudoku_pkg::NUM_CELLS,
   parameter int MAX_DIGIT = sudoku_pkg::MAX_DIGIT
) (
   input logic           clk,
   input logic           rst,
   board_loader_if.slave bus
);
   import sudoku_pkg::*;

   localparam logic [CELL_IDX_W-1:0] LAST_IDX  = CELL_IDX_W'(NUM_CELLS - 1);
   localparam logic [DIGIT_W-1:0]    MAX_D     = DIGIT_W'(MAX_DIGIT);

   loader_state_t         state_reg, state_next;
   logic [CELL_IDX_W-1:0] cell_cnt_reg, cell_cnt_next;
   logic [CELL_IDX_W-1:0] err_cell_reg, err_cell_next;
   logic [SUM_W-1:0]      sum_reg, sum_next;
   logic                  load_error_reg, load_error_next;
   logic                  accept;
   logic                  digit_ok;
   logic                  last_cell;

`ifdef LOADER_READBACK_EN
   logic [CELL_IDX_W-1:0] rd_idx_reg, rd_idx_next;
   logic                  rd_drain_reg, rd_drain_next;
   logic                  rd_valid_reg, rd_valid_next;
   logic [SUM_W-1:0]      rd_sum_reg, rd_sum_next;
   logic [SUM_W-1:0]      readback_total;

   // The final read's data arrives in the drain cycle, so fold it in before comparing.
   assign readback_total = rd_sum_reg + SUM_W'(bus.mem_data_out);
`else
   logic unused_mem_data;
   assign unused_mem_data = ^bus.mem_data_out;
`endif

   assign accept    = (state_reg == LOAD) && bus.in_valid;
   assign digit_ok  = (bus.in_digit <= MAX_D);
   assign last_cell = (cell_cnt_reg == LAST_IDX);

   always_comb begin
      state_next         = state_reg;
      cell_cnt_next      = cell_cnt_reg;
      sum_next           = sum_reg;
      load_error_next    = load_error_reg;
      err_cell_next      = err_cell_reg;
      bus.in_ready       = 1'b0;
      bus.mem_write_en   = 1'b0;
      bus.mem_read_en    = 1'b0;
      bus.mem_cell_index = '0;
      bus.mem_data_in    = '0;
`ifdef LOADER_READBACK_EN
      rd_idx_next   = rd_idx_reg;
      rd_drain_next = rd_drain_reg;
      rd_valid_next = 1'b0;
      rd_sum_next   = rd_sum_reg;
`endif

      case (state_reg)
         IDLE, ERROR: begin
            if (bus.start) begin
               state_next      = LOAD;
               cell_cnt_next   = '0;
               sum_next        = '0;
               load_error_next = 1'b0;
            end
         end

         LOAD: begin
            bus.in_ready       = 1'b1;
            bus.mem_cell_index = cell_cnt_reg;
            bus.mem_data_in    = bus.in_digit;
            if (accept) begin
               if (digit_ok) begin
                  bus.mem_write_en = 1'b1;
                  sum_next         = sum_reg + SUM_W'(bus.in_digit);
                  if (last_cell) begin
`ifdef LOADER_READBACK_EN
                     state_next    = VERIFY;
                     rd_idx_next   = '0;
                     rd_drain_next = 1'b0;
                     rd_sum_next   = '0;
`else
                     state_next    = DONE;
`endif
                  end else begin
                     cell_cnt_next = cell_cnt_reg + 1'b1;
                  end
               end else begin
                  state_next      = ERROR;
                  err_cell_next   = cell_cnt_reg;
                  load_error_next = 1'b1;
               end
            end
         end

`ifdef LOADER_READBACK_EN
         VERIFY: begin
            if (rd_valid_reg)
               rd_sum_next = readback_total;
            if (!rd_drain_reg) begin
               bus.mem_read_en    = 1'b1;
               bus.mem_cell_index = rd_idx_reg;
               rd_valid_next      = 1'b1;
               if (rd_idx_reg == LAST_IDX)
                  rd_drain_next = 1'b1;
               else
                  rd_idx_next = rd_idx_reg + 1'b1;
            end else if (readback_total == sum_reg) begin
               state_next = DONE;
            end else begin
               state_next      = ERROR;
               err_cell_next   = CHECKSUM_ERR_CELL;
               load_error_next = 1'b1;
            end
         end
`endif

         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cell_cnt_reg   <= '0;
         sum_reg        <= '0;
         load_error_reg <= 1'b0;
         err_cell_reg   <= '0;
`ifdef LOADER_READBACK_EN
         rd_idx_reg     <= '0;
         rd_drain_reg   <= 1'b0;
         rd_valid_reg   <= 1'b0;
         rd_sum_reg     <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         cell_cnt_reg   <= cell_cnt_next;
         sum_reg        <= sum_next;
         load_error_reg <= load_error_next;
         err_cell_reg   <= err_cell_next;
`ifdef LOADER_READBACK_EN
         rd_idx_reg     <= rd_idx_next;
         rd_drain_reg   <= rd_drain_next;
         rd_valid_reg   <= rd_valid_next;
         rd_sum_reg     <= rd_sum_next;
`endif
      end
   end

   assign bus.busy       = (state_reg != IDLE);
   assign bus.load_done  = (state_reg == DONE);
   assign bus.load_error = load_error_reg;
   assign bus.err_cell   = err_cell_reg;
endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader with a behavioural board memory beside it.
// Works with and without LOADER_READBACK_EN.
module tb_board_loader;
   import sudoku_pkg::*;

`ifdef LOADER_READBACK_EN
   localparam int EXP_LAT = 83;
`else
   localparam int EXP_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   board_loader_if bus();

   board_loader #(.NUM_CELLS(81), .MAX_DIGIT(9)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [3:0] mem [0:127];
   logic [3:0] rd_q = 4'h0;
   bit         corrupt = 1'b0;
   int         done_cnt = 0;
   int         wr_idx_q[$];
   int         wr_dat_q[$];

   assign bus.mem_data_out = rd_q;

   always @(posedge clk) begin
      if (bus.mem_write_en) begin
         mem[bus.mem_cell_index] <= bus.mem_data_in;
         wr_idx_q.push_back(int'(bus.mem_cell_index));
         wr_dat_q.push_back(int'(bus.mem_data_in));
      end
      if (bus.mem_read_en)
         rd_q <= (corrupt && bus.mem_cell_index == 7'd30) ?
                 (mem[bus.mem_cell_index] ^ 4'h1) : mem[bus.mem_cell_index];
      if (bus.load_done === 1'b1)
         done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs on the falling edge; checks follow 1 ns later, away from posedge.
   task automatic cyc(input logic r, input logic s, input logic v, input logic [3:0] d);
      @(negedge clk);
      rst          = r;
      bus.start    = s;
      bus.in_valid = v;
      bus.in_digit = d;
      #1;
   endtask

   task automatic clear_log();
      wr_idx_q.delete();
      wr_dat_q.delete();
      done_cnt = 0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         cyc(0, 0, 0, 4'h0);
         lat++;
      end while (bus.load_done !== 1'b1 && lat < 200);
   endtask

   task automatic check_writes(input string tag, input int mul);
      int bad;
      bad = 0;
      chk({tag, "_wr_count"}, wr_idx_q.size(), 81);
      for (int i = 0; i < wr_idx_q.size(); i++)
         if (wr_idx_q[i] != i || wr_dat_q[i] != (i * mul) % 10)
            bad++;
      chk({tag, "_wr_bad"}, bad, 0);
   endtask

   initial begin
      int lat;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_digit = 4'h0;
      rst = 1'b1;

      // Reset state
      cyc(1, 0, 0, 4'h0);
      cyc(1, 1, 1, 4'h3);
      chk("rst_busy", bus.busy, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_load_done", bus.load_done, 0);
      chk("rst_load_error", bus.load_error, 0);
      chk("rst_err_cell", bus.err_cell, 7'h00);
      chk("rst_wr_en", bus.mem_write_en, 0);
      chk("rst_rd_en", bus.mem_read_en, 0);

      // Full load, no gaps, digit = i mod 10
      cyc(0, 0, 0, 4'h0);
      chk("idle_wr_count", wr_idx_q.size(), 0);
      clear_log();
      cyc(0, 1, 0, 4'h0);
      for (int i = 0; i < 81; i++) begin
         cyc(0, 0, 1, 4'(i % 10));
         if (i == 0) begin
            chk("a_in_ready", bus.in_ready, 1);
            chk("a_wr_en0", bus.mem_write_en, 1);
            chk("a_idx0", bus.mem_cell_index, 0);
            chk("a_busy", bus.busy, 1);
         end
      end
      wait_done(lat);
      chk("a_done_latency", lat, EXP_LAT);
      cyc(0, 0, 0, 4'h0);
      chk("a_done_pulse_end", bus.load_done, 0);
      chk("a_busy_idle", bus.busy, 0);
      chk("a_done_cnt", done_cnt, 1);
      chk("a_load_error", bus.load_error, 0);
      check_writes("a", 1);

      // Illegal digit at cell 5
      clear_log();
      cyc(0, 1, 0, 4'h0);
      for (int i = 0; i < 5; i++)
         cyc(0, 0, 1, 4'h1);
      cyc(0, 0, 1, 4'hA);
      chk("b_wr_en_bad", bus.mem_write_en, 0);
      cyc(0, 0, 1, 4'h3);
      chk("b_load_error", bus.load_error, 1);
      chk("b_err_cell", bus.err_cell, 5);
      chk("b_in_ready", bus.in_ready, 0);
      chk("b_wr_en_err", bus.mem_write_en, 0);
      chk("b_busy", bus.busy, 1);
      cyc(0, 0, 1, 4'h3);
      chk("b_error_hold", bus.load_error, 1);
      chk("b_wr_count", wr_idx_q.size(), 5);

      // Restart clears the error; a start mid-load is ignored
      cyc(0, 1, 0, 4'h0);
      cyc(0, 0, 0, 4'h0);
      chk("b_restart_err", bus.load_error, 0);
      chk("b_restart_ready", bus.in_ready, 1);
      clear_log();
      for (int i = 0; i < 81; i++)
         cyc(0, (i == 20), 1, 4'((i * 7) % 10));
      wait_done(lat);
      chk("f_done_latency", lat, EXP_LAT);
      cyc(0, 0, 0, 4'h0);
      chk("f_done_cnt", done_cnt, 1);
      check_writes("f", 7);

      // in_valid every other cycle
      clear_log();
      cyc(0, 1, 0, 4'h0);
      for (int i = 0; i < 81; i++) begin
         cyc(0, 0, 1, 4'((i * 3) % 10));
         if (i < 80) begin
            cyc(0, 0, 0, 4'h9);
            if (i == 0) begin
               chk("c_gap_wr_en", bus.mem_write_en, 0);
               chk("c_gap_ready", bus.in_ready, 1);
            end
         end
      end
      wait_done(lat);
      chk("c_done_latency", lat, EXP_LAT);
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 4'h0);
      chk("c_done_cnt", done_cnt, 1);
      check_writes("c", 3);

      // Reset after 40 accepts
      clear_log();
      cyc(0, 1, 0, 4'h0);
      for (int i = 0; i < 40; i++)
         cyc(0, 0, 1, 4'h2);
      cyc(1, 0, 0, 4'h0);
      cyc(0, 0, 1, 4'h5);
      chk("d_busy", bus.busy, 0);
      chk("d_in_ready", bus.in_ready, 0);
      chk("d_wr_en", bus.mem_write_en, 0);
      cyc(0, 0, 1, 4'h5);
      chk("d_wr_count", wr_idx_q.size(), 40);
      cyc(0, 1, 1, 4'h9);
      chk("d_idle_no_wr", bus.mem_write_en, 0);
      cyc(0, 0, 1, 4'h4);
      chk("d_restart_wr", bus.mem_write_en, 1);
      chk("d_restart_idx", bus.mem_cell_index, 0);
      chk("d_restart_data", bus.mem_data_in, 4);
      cyc(1, 0, 0, 4'h0);
      cyc(0, 0, 0, 4'h0);
      chk("d_rst_busy", bus.busy, 0);
      chk("d_rst_err_cell", bus.err_cell, 0);

`ifdef LOADER_READBACK_EN
      // Read-back checksum failure
      corrupt = 1'b1;
      clear_log();
      cyc(0, 1, 0, 4'h0);
      for (int i = 0; i < 81; i++)
         cyc(0, 0, 1, 4'(i % 10));
      lat = 0;
      do begin
         cyc(0, 0, 0, 4'h0);
         lat++;
      end while (bus.load_error !== 1'b1 && bus.load_done !== 1'b1 && lat < 200);
      chk("e_load_error", bus.load_error, 1);
      chk("e_err_cell", bus.err_cell, 7'h7F);
      chk("e_done_cnt", done_cnt, 0);
      corrupt = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
